pipelined_fetch_unit: RTL and testbench

- Parametrised instruction-fetch stage for the ARMv8 core; the next generation of the single-cycle datapath's PC logic.
- Owns the program counter and drives the instruction-memory word address.
- Captures {pc, instruction} into an IF/ID pipeline register with valid, stall and flush control.
- Accepts branch redirects from downstream and keeps a saturating fetch-count performance counter.

---
 rtl/pipelined_fetch_unit.sv | 104 ++++++++++
 tb/tb_pipelined_fetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_fetch_unit.sv
// Instruction-fetch stage. It owns the program counter, drives the
// instruction-memory word address, and captures {pc, instruction} into the
// IF/ID pipeline register.
// A downstream branch redirect flushes the IF/ID register and wins over a
// decode stall. A saturating counter records how many instructions entered
// IF/ID.
module pipelined_fetch_unit #(
    parameter int              PC_W     = 64,
    parameter int              IM_AW    = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32,
    parameter logic [31:0]     NOP_INST = 32'hD503201F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_target,
    input  logic [31:0]      inst_in,
    output logic [IM_AW-1:0] im_addr,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  ifid_pc,
    output logic [31:0]      ifid_inst,
    output logic             ifid_valid,
    output logic             misalign,
    output logic [CNT_W-1:0] fetch_cnt
);

    // The low two bits are forced clear so that a careless RESET_PC can never
    // start fetching from a misaligned address.
    localparam logic [PC_W-1:0] RESET_PC_ALIGNED = {RESET_PC[PC_W-1:2], 2'b00};
    localparam logic [PC_W-1:0] PC_STEP          = PC_W'(4);
    localparam logic [CNT_W-1:0] CNT_ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX         = '1;

    logic [PC_W-1:0]  pc_q,         pc_d;
    logic [PC_W-1:0]  ifid_pc_q,    ifid_pc_d;
    logic [31:0]      ifid_inst_q,  ifid_inst_d;
    logic             ifid_valid_q, ifid_valid_d;
    logic             misalign_q,   misalign_d;
    logic [CNT_W-1:0] fetch_cnt_q,  fetch_cnt_d;

    // Word address into the instruction memory. A PC beyond the memory simply
    // aliases onto its low word bits, and no error is raised.
    assign im_addr = pc_q[IM_AW+1:2];

    // Next-state selection. The priority order is redirect, then stall, then
    // a normal sequential fetch.
    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_valid_d = ifid_valid_q;
        fetch_cnt_d  = fetch_cnt_q;
        misalign_d   = 1'b0;

        if (br_taken) begin
            // On a redirect, the target is word-aligned before use.
            // The instruction already in IF/ID is on the wrong path, so it
            // is replaced by a bubble.
            pc_d         = {br_target[PC_W-1:2], 2'b00};
            ifid_pc_d    = '0;
            ifid_inst_d  = NOP_INST;
            ifid_valid_d = 1'b0;
            misalign_d   = |br_target[1:0];
        end else if (!stall) begin
            // The PC wraps modulo 2**PC_W without any indication.
            pc_d         = pc_q + PC_STEP;
            ifid_pc_d    = pc_q;
            ifid_inst_d  = inst_in;
            ifid_valid_d = 1'b1;
            if (fetch_cnt_q != CNT_MAX) begin
                fetch_cnt_d = fetch_cnt_q + CNT_ONE;
            end
        end
    end

    // Fetch state registers, with asynchronous return to the reset state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC_ALIGNED;
            ifid_pc_q    <= '0;
            ifid_inst_q  <= NOP_INST;
            ifid_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            fetch_cnt_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_valid_q <= ifid_valid_d;
            misalign_q   <= misalign_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    assign pc         = pc_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_inst  = ifid_inst_q;
    assign ifid_valid = ifid_valid_q;
    assign misalign   = misalign_q;
    assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_pipelined_fetch_unit.sv
// Directed bench for pipelined_fetch_unit. It runs three instances:
//   a: default parameters
//   b: PC_W=8, IM_AW=6, RESET_PC=0x20 (PC wrap and non-zero reset PC)
//   c: CNT_W=3 (counter saturation)
// Word k of each instruction memory holds 32'h1000_0000 + k.
module tb_pipelined_fetch_unit;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [63:0] br_target;

    logic [31:0] inst_a, inst_b, inst_c;
    logic [8:0]  im_addr_a, im_addr_c;
    logic [5:0]  im_addr_b;
    logic [63:0] pc_a, ifid_pc_a, pc_c, ifid_pc_c;
    logic [7:0]  pc_b, ifid_pc_b;
    logic [31:0] ifid_inst_a, ifid_inst_b, ifid_inst_c;
    logic        ifid_valid_a, ifid_valid_b, ifid_valid_c;
    logic        misalign_a, misalign_b, misalign_c;
    logic [31:0] fetch_cnt_a, fetch_cnt_b;
    logic [2:0]  fetch_cnt_c;

    int total;
    int bad;

    assign inst_a = 32'h1000_0000 + {23'd0, im_addr_a};
    assign inst_b = 32'h1000_0000 + {26'd0, im_addr_b};
    assign inst_c = 32'h1000_0000 + {23'd0, im_addr_c};

    pipelined_fetch_unit u_a (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .inst_in(inst_a), .im_addr(im_addr_a),
        .pc(pc_a), .ifid_pc(ifid_pc_a), .ifid_inst(ifid_inst_a),
        .ifid_valid(ifid_valid_a), .misalign(misalign_a), .fetch_cnt(fetch_cnt_a)
    );

    pipelined_fetch_unit #(.PC_W(8), .IM_AW(6), .RESET_PC(8'h20)) u_b (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken),
        .br_target(br_target[7:0]), .inst_in(inst_b), .im_addr(im_addr_b),
        .pc(pc_b), .ifid_pc(ifid_pc_b), .ifid_inst(ifid_inst_b),
        .ifid_valid(ifid_valid_b), .misalign(misalign_b), .fetch_cnt(fetch_cnt_b)
    );

    pipelined_fetch_unit #(.CNT_W(3)) u_c (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .inst_in(inst_c), .im_addr(im_addr_c),
        .pc(pc_c), .ifid_pc(ifid_pc_c), .ifid_inst(ifid_inst_c),
        .ifid_valid(ifid_valid_c), .misalign(misalign_c), .fetch_cnt(fetch_cnt_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge, then settle 1 ns so that outputs are sampled
    // away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse placed between edges; the reset is asynchronous.
    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
        tick();
        $display("reset: pc=%h ifid_pc=%h inst=%h valid=%b cnt=%0d",
                 pc_a, ifid_pc_a, ifid_inst_a, ifid_valid_a, fetch_cnt_a);
        total++; if (pc_a !== 64'd0) begin bad++; $display("FAIL reset_pc got %h want 0", pc_a); end
        total++; if (ifid_pc_a !== 64'd0) begin bad++; $display("FAIL reset_ifid_pc got %h want 0", ifid_pc_a); end
        total++; if (ifid_inst_a !== NOP) begin bad++; $display("FAIL reset_ifid_inst got %h want %h", ifid_inst_a, NOP); end
        total++; if (ifid_valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", ifid_valid_a); end
        total++; if (misalign_a !== 1'b0) begin bad++; $display("FAIL reset_misalign got %b want 0", misalign_a); end
        total++; if (fetch_cnt_a !== 32'd0) begin bad++; $display("FAIL reset_cnt got %0d want 0", fetch_cnt_a); end
        total++; if (pc_b !== 8'h20) begin bad++; $display("FAIL reset_pc_b got %h want 20", pc_b); end
        total++; if (im_addr_b !== 6'd8) begin bad++; $display("FAIL reset_im_addr_b got %0d want 8", im_addr_b); end
        rst = 1'b0;
    endtask

    task automatic test_sequential_fetch();
        for (int k = 0; k < 4; k++) begin
            tick();
            $display("fetch %0d: pc=%h ifid_pc=%h inst=%h valid=%b cnt=%0d",
                     k, pc_a, ifid_pc_a, ifid_inst_a, ifid_valid_a, fetch_cnt_a);
            total++; if (pc_a !== 64'(4 * (k + 1))) begin bad++; $display("FAIL seq_pc[%0d] got %h want %h", k, pc_a, 4 * (k + 1)); end
            total++; if (ifid_pc_a !== 64'(4 * k)) begin bad++; $display("FAIL seq_ifid_pc[%0d] got %h want %h", k, ifid_pc_a, 4 * k); end
            total++; if (ifid_inst_a !== 32'h1000_0000 + 32'(k)) begin bad++; $display("FAIL seq_inst[%0d] got %h want %h", k, ifid_inst_a, 32'h1000_0000 + 32'(k)); end
            total++; if (ifid_valid_a !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got %b want 1", k, ifid_valid_a); end
        end
        total++; if (fetch_cnt_a !== 32'd4) begin bad++; $display("FAIL seq_cnt got %0d want 4", fetch_cnt_a); end
        // Instance b started at 0x20, so after four fetches it holds word 0x0B.
        $display("fetch b: pc=%h ifid_pc=%h inst=%h", pc_b, ifid_pc_b, ifid_inst_b);
        total++; if (pc_b !== 8'h30) begin bad++; $display("FAIL seq_pc_b got %h want 30", pc_b); end
        total++; if (ifid_pc_b !== 8'h2C) begin bad++; $display("FAIL seq_ifid_pc_b got %h want 2c", ifid_pc_b); end
        total++; if (ifid_inst_b !== 32'h1000_000B) begin bad++; $display("FAIL seq_inst_b got %h want 1000000b", ifid_inst_b); end
    endtask

    task automatic test_stall();
        pulse_reset();
        tick();
        tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            $display("stall %0d: pc=%h ifid_pc=%h valid=%b cnt=%0d", k, pc_a, ifid_pc_a, ifid_valid_a, fetch_cnt_a);
            total++; if (pc_a !== 64'd8) begin bad++; $display("FAIL stall_pc[%0d] got %h want 8", k, pc_a); end
            total++; if (ifid_pc_a !== 64'd4) begin bad++; $display("FAIL stall_ifid_pc[%0d] got %h want 4", k, ifid_pc_a); end
            total++; if (ifid_inst_a !== 32'h1000_0001) begin bad++; $display("FAIL stall_inst[%0d] got %h want 10000001", k, ifid_inst_a); end
            total++; if (ifid_valid_a !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got %b want 1", k, ifid_valid_a); end
            total++; if (fetch_cnt_a !== 32'd2) begin bad++; $display("FAIL stall_cnt[%0d] got %0d want 2", k, fetch_cnt_a); end
        end
        stall = 1'b0;
        tick();
        $display("release: pc=%h ifid_pc=%h inst=%h cnt=%0d", pc_a, ifid_pc_a, ifid_inst_a, fetch_cnt_a);
        total++; if (pc_a !== 64'd12) begin bad++; $display("FAIL release_pc got %h want c", pc_a); end
        total++; if (ifid_pc_a !== 64'd8) begin bad++; $display("FAIL release_ifid_pc got %h want 8", ifid_pc_a); end
        total++; if (ifid_inst_a !== 32'h1000_0002) begin bad++; $display("FAIL release_inst got %h want 10000002", ifid_inst_a); end
        total++; if (fetch_cnt_a !== 32'd3) begin bad++; $display("FAIL release_cnt got %0d want 3", fetch_cnt_a); end
    endtask

    task automatic test_branch_over_stall();
        br_taken = 1'b1; stall = 1'b1; br_target = 64'h40;
        tick();
        $display("branch: pc=%h ifid_pc=%h inst=%h valid=%b", pc_a, ifid_pc_a, ifid_inst_a, ifid_valid_a);
        total++; if (pc_a !== 64'h40) begin bad++; $display("FAIL br_pc got %h want 40", pc_a); end
        total++; if (ifid_valid_a !== 1'b0) begin bad++; $display("FAIL br_valid got %b want 0", ifid_valid_a); end
        total++; if (ifid_inst_a !== NOP) begin bad++; $display("FAIL br_inst got %h want %h", ifid_inst_a, NOP); end
        total++; if (ifid_pc_a !== 64'd0) begin bad++; $display("FAIL br_ifid_pc got %h want 0", ifid_pc_a); end
        total++; if (misalign_a !== 1'b0) begin bad++; $display("FAIL br_misalign got %b want 0", misalign_a); end
        total++; if (fetch_cnt_a !== 32'd3) begin bad++; $display("FAIL br_cnt got %0d want 3", fetch_cnt_a); end
        br_taken = 1'b0; stall = 1'b0;
        tick();
        $display("after branch: pc=%h ifid_pc=%h inst=%h valid=%b", pc_a, ifid_pc_a, ifid_inst_a, ifid_valid_a);
        total++; if (ifid_pc_a !== 64'h40) begin bad++; $display("FAIL br_next_ifid_pc got %h want 40", ifid_pc_a); end
        total++; if (ifid_valid_a !== 1'b1) begin bad++; $display("FAIL br_next_valid got %b want 1", ifid_valid_a); end
        total++; if (ifid_inst_a !== 32'h1000_0010) begin bad++; $display("FAIL br_next_inst got %h want 10000010", ifid_inst_a); end
        total++; if (pc_a !== 64'h44) begin bad++; $display("FAIL br_next_pc got %h want 44", pc_a); end
        total++; if (fetch_cnt_a !== 32'd4) begin bad++; $display("FAIL br_next_cnt got %0d want 4", fetch_cnt_a); end
    endtask

    task automatic test_misalign();
        br_taken = 1'b1; br_target = 64'h46;
        tick();
        $display("misalign: pc=%h misalign=%b valid=%b", pc_a, misalign_a, ifid_valid_a);
        total++; if (pc_a !== 64'h44) begin bad++; $display("FAIL mis_pc got %h want 44", pc_a); end
        total++; if (misalign_a !== 1'b1) begin bad++; $display("FAIL mis_pulse got %b want 1", misalign_a); end
        total++; if (ifid_valid_a !== 1'b0) begin bad++; $display("FAIL mis_valid got %b want 0", ifid_valid_a); end
        br_taken = 1'b0;
        tick();
        $display("misalign next: pc=%h misalign=%b ifid_pc=%h inst=%h", pc_a, misalign_a, ifid_pc_a, ifid_inst_a);
        total++; if (misalign_a !== 1'b0) begin bad++; $display("FAIL mis_clear got %b want 0", misalign_a); end
        total++; if (ifid_pc_a !== 64'h44) begin bad++; $display("FAIL mis_ifid_pc got %h want 44", ifid_pc_a); end
        total++; if (ifid_inst_a !== 32'h1000_0011) begin bad++; $display("FAIL mis_inst got %h want 10000011", ifid_inst_a); end
    endtask

    task automatic test_pc_wrap();
        br_taken = 1'b1; br_target = 64'hFC;
        tick();
        br_taken = 1'b0;
        $display("wrap setup: pc_b=%h im_addr_b=%0d", pc_b, im_addr_b);
        total++; if (pc_b !== 8'hFC) begin bad++; $display("FAIL wrap_setup_pc got %h want fc", pc_b); end
        tick();
        $display("wrap: pc_b=%h ifid_pc_b=%h inst_b=%h pc_a=%h", pc_b, ifid_pc_b, ifid_inst_b, pc_a);
        total++; if (pc_b !== 8'h00) begin bad++; $display("FAIL wrap_pc got %h want 00", pc_b); end
        total++; if (ifid_pc_b !== 8'hFC) begin bad++; $display("FAIL wrap_ifid_pc got %h want fc", ifid_pc_b); end
        total++; if (ifid_inst_b !== 32'h1000_003F) begin bad++; $display("FAIL wrap_inst got %h want 1000003f", ifid_inst_b); end
        // The 64-bit instance does not wrap here.
        total++; if (pc_a !== 64'h100) begin bad++; $display("FAIL nowrap_pc_a got %h want 100", pc_a); end
    endtask

    task automatic test_alias();
        // 0x804 lies past the 512-word memory and aliases to word 1.
        br_taken = 1'b1; br_target = 64'h804;
        tick();
        br_taken = 1'b0;
        $display("alias: pc=%h im_addr=%0d misalign=%b", pc_a, im_addr_a, misalign_a);
        total++; if (im_addr_a !== 9'd1) begin bad++; $display("FAIL alias_addr got %0d want 1", im_addr_a); end
        total++; if (misalign_a !== 1'b0) begin bad++; $display("FAIL alias_misalign got %b want 0", misalign_a); end
        tick();
        total++; if (ifid_inst_a !== 32'h1000_0001) begin bad++; $display("FAIL alias_inst got %h want 10000001", ifid_inst_a); end
        total++; if (ifid_pc_a !== 64'h804) begin bad++; $display("FAIL alias_ifid_pc got %h want 804", ifid_pc_a); end
    endtask

    task automatic test_counter_sat_and_reset();
        pulse_reset();
        for (int k = 0; k < 10; k++) begin
            tick();
            $display("count %0d: cnt_c=%0d cnt_a=%0d", k, fetch_cnt_c, fetch_cnt_a);
            total++; if (fetch_cnt_c !== ((k + 1 > 7) ? 3'd7 : 3'(k + 1))) begin bad++; $display("FAIL sat_cnt[%0d] got %0d want %0d", k, fetch_cnt_c, (k + 1 > 7) ? 7 : k + 1); end
        end
        total++; if (fetch_cnt_a !== 32'd10) begin bad++; $display("FAIL wide_cnt got %0d want 10", fetch_cnt_a); end
        total++; if (pc_c !== 64'd40) begin bad++; $display("FAIL sat_pc got %h want 28", pc_c); end
        // Leave misalign set, then reset mid-cycle; everything must clear before the next edge.
        br_taken = 1'b1; br_target = 64'h7;
        tick();
        total++; if (misalign_a !== 1'b1) begin bad++; $display("FAIL pre_rst_misalign got %b want 1", misalign_a); end
        br_taken = 1'b0;
        rst = 1'b1;
        #2;
        $display("mid reset: pc=%h ifid_pc=%h inst=%h valid=%b mis=%b cnt_c=%0d",
                 pc_a, ifid_pc_a, ifid_inst_a, ifid_valid_a, misalign_a, fetch_cnt_c);
        total++; if (pc_a !== 64'd0) begin bad++; $display("FAIL mid_rst_pc got %h want 0", pc_a); end
        total++; if (ifid_pc_a !== 64'd0) begin bad++; $display("FAIL mid_rst_ifid_pc got %h want 0", ifid_pc_a); end
        total++; if (ifid_inst_a !== NOP) begin bad++; $display("FAIL mid_rst_inst got %h want %h", ifid_inst_a, NOP); end
        total++; if (ifid_valid_a !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got %b want 0", ifid_valid_a); end
        total++; if (misalign_a !== 1'b0) begin bad++; $display("FAIL mid_rst_misalign got %b want 0", misalign_a); end
        total++; if (fetch_cnt_a !== 32'd0) begin bad++; $display("FAIL mid_rst_cnt_a got %0d want 0", fetch_cnt_a); end
        total++; if (fetch_cnt_c !== 3'd0) begin bad++; $display("FAIL mid_rst_cnt_c got %0d want 0", fetch_cnt_c); end
        rst = 1'b0;
        tick();
        $display("post reset: pc=%h ifid_pc=%h inst=%h valid=%b", pc_a, ifid_pc_a, ifid_inst_a, ifid_valid_a);
        total++; if (ifid_inst_a !== 32'h1000_0000) begin bad++; $display("FAIL post_rst_inst got %h want 10000000", ifid_inst_a); end
        total++; if (ifid_pc_a !== 64'd0) begin bad++; $display("FAIL post_rst_ifid_pc got %h want 0", ifid_pc_a); end
        total++; if (ifid_valid_a !== 1'b1) begin bad++; $display("FAIL post_rst_valid got %b want 1", ifid_valid_a); end
        total++; if (pc_a !== 64'd4) begin bad++; $display("FAIL post_rst_pc got %h want 4", pc_a); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
        test_reset();
        test_sequential_fetch();
        test_stall();
        test_branch_over_stall();
        test_misalign();
        test_pc_wrap();
        test_alias();
        test_counter_sat_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
